// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and operand/result bundle between the ALU opcode decoder, the
// bit-serial add/subtract sequencer and the result mux.
interface serial_addsub_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, A, B,
        input  Sum, Cout, Overflow, busy, done
    );

    modport slave (
        input  start, sub, A, B,
        output Sum, Cout, Overflow, busy, done
    );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder evaluation per clk, LSB first.
// Optional signed saturation of the final result: define SERIAL_ADDSUB_SAT_EN.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_addsub_ctrl_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | one operand bit pair per cycle, LSB first
    // DONE  | result valid, done pulse; start here chains straight into RUN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`ifdef SERIAL_ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             load;
    logic             fa_s;
    logic             fa_co;
    logic             ovf_term;
    logic [WIDTH-1:0] sum_shift;

    // The shared one-bit full-adder cell; returns {carry, sum}.
    function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    always_comb begin
        {fa_co, fa_s} = full_adder(ra_q[0], rb_q[0], c_q);
        sum_shift     = {fa_s, sum_q[WIDTH-1:1]};
        // c_q is the carry into the bit being processed, i.e. into the MSB on the last cycle.
        ovf_term      = c_q ^ fa_co;
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                ra_d  = {1'b0, ra_q[WIDTH-1:1]};
                rb_d  = {1'b0, rb_q[WIDTH-1:1]};
                sum_d = sum_shift;
                c_d   = fa_co;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cout_d  = fa_co;
                    ovf_d   = ovf_term;
`ifdef SERIAL_ADDSUB_SAT_EN
                    // A wrapped MSB of 1 means the true result was positive.
                    if (ovf_term) begin
                        sum_d = fa_s ? SAT_MAX : SAT_MIN;
                    end
`endif
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
        if (load) begin
            ra_d  = bus.A;
            rb_d  = bus.B ^ {WIDTH{bus.sub}};
            c_d   = bus.sub;
            cnt_d = '0;
        end

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Sum      = sum_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
